// File: rtl/interrupt_core.sv
// rtl/interrupt_core.sv - N-channel interrupt controller: capture, mask, rotating priority, in-service tracking, INTA/EOI.
module interrupt_core #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             level_mode,
    input  logic [N_IRQ-1:0] mask,
    input  logic             rotate_en,
    input  logic             aeoi,
    input  logic             inta,
    input  logic             eoi_valid,
    input  logic             eoi_specific,
    input  logic [ID_W-1:0]  eoi_id,
    output logic             int_out,
    output logic             vec_valid,
    output logic [ID_W-1:0]  vec_id,
    output logic             vec_spurious,
    output logic [N_IRQ-1:0] irr_out,
    output logic [N_IRQ-1:0] isr_out
);
    typedef enum logic {IDLE, ACK1} state_t;

    state_t           state, state_next;
    logic [N_IRQ-1:0] prev_irq, irr, isr;
    logic [N_IRQ-1:0] req, irr_next, isr_next;
    logic [N_IRQ-1:0] isr_set, irr_clr, aeoi_clr, eoi_clr;
    logic [ID_W-1:0]  lp, lp_eff, lp_next, ack_id, ack_id_next;
    logic             spur_flag, spur_next, vec_fire, int_next;
    logic             w_found, isr_found, eoi_hit;
    logic [ID_W-1:0]  w_id, isr_top, eoi_ch, chi;
    int               w_rank, isr_rank, ch;

    assign lp_eff = rotate_en ? lp : ID_W'(N_IRQ-1);
    assign req    = irr & ~mask;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        w_found   = 1'b0;
        w_id      = '0;
        w_rank    = N_IRQ;
        isr_found = 1'b0;
        isr_top   = '0;
        isr_rank  = N_IRQ;
        ch        = 0;
        chi       = '0;
        for (int k = N_IRQ-1; k >= 0; k--) begin
            ch  = (int'(lp_eff) + 1 + k) % N_IRQ;
            chi = ID_W'(ch);
            if (req[chi]) begin
                w_found = 1'b1;
                w_id    = chi;
                w_rank  = k;
            end
            if (isr[chi]) begin
                isr_found = 1'b1;
                isr_top   = chi;
                isr_rank  = k;
            end
        end
    end

    always_comb begin
        eoi_hit = 1'b0;
        eoi_ch  = '0;
        eoi_clr = '0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                if (int'(eoi_id) < N_IRQ && isr[eoi_id]) begin
                    eoi_hit = 1'b1;
                    eoi_ch  = eoi_id;
                end
            end else if (isr_found) begin
                eoi_hit = 1'b1;
                eoi_ch  = isr_top;
            end
        end
        if (eoi_hit) begin
            eoi_clr[eoi_ch] = 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        ack_id_next = ack_id;
        spur_next   = spur_flag;
        isr_set     = '0;
        irr_clr     = '0;
        aeoi_clr    = '0;
        vec_fire    = 1'b0;
        lp_next     = lp_eff;
        case (state)
            IDLE: begin
                if (inta) begin
                    state_next = ACK1;
                    if (w_found) begin
                        ack_id_next   = w_id;
                        spur_next     = 1'b0;
                        isr_set[w_id] = 1'b1;
                        if (!level_mode) begin
                            irr_clr[w_id] = 1'b1;
                        end
                    end else begin
                        ack_id_next = ID_W'(N_IRQ-1);
                        spur_next   = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta) begin
                    state_next = IDLE;
                    vec_fire   = 1'b1;
                    if (aeoi && !spur_flag) begin
                        aeoi_clr[ack_id] = 1'b1;
                        if (rotate_en) begin
                            lp_next = ack_id;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // An explicit EOI overrides any automatic-EOI rotation in the same cycle.
        if (eoi_hit && rotate_en) begin
            lp_next = eoi_ch;
        end
    end

    // Set terms are OR-ed last so a new request or acknowledge beats a clear.
    assign isr_next = (isr & ~(eoi_clr | aeoi_clr)) | isr_set;
    assign irr_next = level_mode ? irq_in : ((irr & ~irr_clr) | (irq_in & ~prev_irq));
    assign int_next = (state == IDLE) && w_found && (!isr_found || w_rank < isr_rank);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            prev_irq     <= '0;
            irr          <= '0;
            isr          <= '0;
            lp           <= ID_W'(N_IRQ-1);
            ack_id       <= '0;
            spur_flag    <= 1'b0;
            int_out      <= 1'b0;
            vec_valid    <= 1'b0;
            vec_id       <= '0;
            vec_spurious <= 1'b0;
        end else begin
            state     <= state_next;
            prev_irq  <= irq_in;
            irr       <= irr_next;
            isr       <= isr_next;
            lp        <= lp_next;
            ack_id    <= ack_id_next;
            spur_flag <= spur_next;
            int_out   <= int_next;
            vec_valid <= vec_fire;
            if (vec_fire) begin
                vec_id       <= ack_id;
                vec_spurious <= spur_flag;
            end
        end
    end

    assign irr_out = irr;
    assign isr_out = isr;
endmodule

// File: tb/tb_interrupt_core.sv
// tb/tb_interrupt_core.sv - directed scenarios plus randomized run against a priority/rank reference model.
module tb_interrupt_core;
    localparam int N = 8;

    logic         clk, reset;
    logic [N-1:0] irq_in, mask;
    logic         level_mode, rotate_en, aeoi, inta, eoi_valid, eoi_specific;
    logic [2:0]   eoi_id;
    logic         int_out, vec_valid, vec_spurious;
    logic [2:0]   vec_id;
    logic [N-1:0] irr_out, isr_out;

    int n_checks = 0;
    int n_pass   = 0;

    interrupt_core #(.N_IRQ(N)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .level_mode(level_mode),
        .mask(mask), .rotate_en(rotate_en), .aeoi(aeoi), .inta(inta),
        .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_id(eoi_id),
        .int_out(int_out), .vec_valid(vec_valid), .vec_id(vec_id),
        .vec_spurious(vec_spurious), .irr_out(irr_out), .isr_out(isr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: priority expressed as a rank distance from the lowest-priority channel.
    bit [N-1:0] m_irr = '0, m_isr = '0, m_prev = '0;
    int         m_lp = N-1, m_ack_id = 0, m_vid = 0;
    bit         m_in_ack = 0, m_spur = 0, m_int = 0, m_vv = 0, m_vsp = 0;

    function automatic int rank(int c, int lpv);
        return (c - lpv - 1 + N) % N;
    endfunction

    function automatic int best(bit [N-1:0] v, int lpv);
        int b = -1;
        for (int c = 0; c < N; c++)
            if (v[c] && (b < 0 || rank(c, lpv) < rank(b, lpv))) b = c;
        return b;
    endfunction

    task automatic model_step();
        int lpv, w, t, e, nlp;
        bit was_ack;
        bit [N-1:0] nisr, acl;
        if (reset) begin
            m_irr = '0; m_isr = '0; m_prev = '0; m_lp = N-1; m_in_ack = 0;
            m_ack_id = 0; m_spur = 0; m_int = 0; m_vv = 0; m_vid = 0; m_vsp = 0;
            return;
        end
        was_ack = m_in_ack;
        lpv  = rotate_en ? m_lp : N-1;
        w    = best(m_irr & ~mask, lpv);
        t    = best(m_isr, lpv);
        nisr = m_isr;
        acl  = '0;
        nlp  = lpv;
        e    = -1;
        if (eoi_valid) e = eoi_specific ? (m_isr[eoi_id] ? int'(eoi_id) : -1) : t;
        if (e >= 0) nisr[e] = 1'b0;
        m_vv = 0;
        if (was_ack && inta) begin
            m_vv = 1; m_vid = m_ack_id; m_vsp = m_spur;
            if (aeoi && !m_spur) begin
                nisr[m_ack_id] = 1'b0;
                if (rotate_en) nlp = m_ack_id;
            end
            m_in_ack = 0;
        end
        if (e >= 0 && rotate_en) nlp = e;
        m_int = !was_ack && w >= 0 && (t < 0 || rank(w, lpv) < rank(t, lpv));
        if (!was_ack && inta) begin
            if (w >= 0) begin
                nisr[w] = 1'b1;
                if (!level_mode) acl[w] = 1'b1;
                m_ack_id = w; m_spur = 0;
            end else begin
                m_ack_id = N-1; m_spur = 1;
            end
            m_in_ack = 1;
        end
        m_irr  = level_mode ? irq_in : ((m_irr & ~acl) | (irq_in & ~m_prev));
        m_prev = irq_in;
        m_isr  = nisr;
        m_lp   = nlp;
    endtask

    always @(posedge clk) model_step();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; inta = 1'b0; eoi_valid = 1'b0; irq_in = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_ack();
        inta = 1'b1;
        tick();
        tick();
        inta = 1'b0;
    endtask

    task automatic do_eoi_ns();
        eoi_valid = 1'b1; eoi_specific = 1'b0;
        tick();
        eoi_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; inta = 1'b1; eoi_valid = 1'b1; irq_in = 8'hff;
        tick(); tick();
        reset = 1'b0; inta = 1'b0; eoi_valid = 1'b0; irq_in = '0;
        n_checks++; if (int_out !== 1'b0) $display("FAIL reset_int got %b want 0", int_out); else n_pass++;
        n_checks++; if (vec_valid !== 1'b0) $display("FAIL reset_vv got %b want 0", vec_valid); else n_pass++;
        n_checks++; if (vec_id !== 3'd0) $display("FAIL reset_vid got %0d want 0", vec_id); else n_pass++;
        n_checks++; if (vec_spurious !== 1'b0) $display("FAIL reset_vsp got %b want 0", vec_spurious); else n_pass++;
        n_checks++; if (irr_out !== 8'h00) $display("FAIL reset_irr got %h want 00", irr_out); else n_pass++;
        n_checks++; if (isr_out !== 8'h00) $display("FAIL reset_isr got %h want 00", isr_out); else n_pass++;
    endtask

    task automatic test_basic_ack();
        do_reset();
        irq_in = 8'h08;
        tick();
        n_checks++; if (irr_out !== 8'h08) $display("FAIL basic_irr_set got %h want 08", irr_out); else n_pass++;
        n_checks++; if (int_out !== 1'b0) $display("FAIL basic_int_lat got %b want 0", int_out); else n_pass++;
        tick();
        n_checks++; if (int_out !== 1'b1) $display("FAIL basic_int_up got %b want 1", int_out); else n_pass++;
        inta = 1'b1;
        tick();
        inta = 1'b0;
        n_checks++; if (isr_out !== 8'h08) $display("FAIL basic_isr1 got %h want 08", isr_out); else n_pass++;
        n_checks++; if (irr_out !== 8'h00) $display("FAIL basic_irr_clr got %h want 00", irr_out); else n_pass++;
        inta = 1'b1;
        tick();
        inta = 1'b0;
        n_checks++; if (vec_valid !== 1'b1) $display("FAIL basic_vv got %b want 1", vec_valid); else n_pass++;
        n_checks++; if (vec_id !== 3'd3) $display("FAIL basic_vid got %0d want 3", vec_id); else n_pass++;
        n_checks++; if (vec_spurious !== 1'b0) $display("FAIL basic_vsp got %b want 0", vec_spurious); else n_pass++;
        n_checks++; if (int_out !== 1'b0) $display("FAIL basic_int_down got %b want 0", int_out); else n_pass++;
        tick();
        n_checks++; if (vec_valid !== 1'b0) $display("FAIL basic_vv_pulse got %b want 0", vec_valid); else n_pass++;
    endtask

    task automatic test_nesting();
        irq_in = 8'h28;
        tick(); tick(); tick();
        n_checks++; if (int_out !== 1'b0) $display("FAIL nest_low_wait got %b want 0", int_out); else n_pass++;
        n_checks++; if (irr_out !== 8'h20) $display("FAIL nest_irr5 got %h want 20", irr_out); else n_pass++;
        irq_in = 8'h2a;
        tick(); tick();
        n_checks++; if (int_out !== 1'b1) $display("FAIL nest_high_int got %b want 1", int_out); else n_pass++;
        do_ack();
        n_checks++; if (vec_id !== 3'd1) $display("FAIL nest_vid got %0d want 1", vec_id); else n_pass++;
        n_checks++; if (isr_out !== 8'h0a) $display("FAIL nest_isr got %h want 0a", isr_out); else n_pass++;
        do_eoi_ns();
        n_checks++; if (isr_out !== 8'h08) $display("FAIL nest_eoi1 got %h want 08", isr_out); else n_pass++;
        tick();
        n_checks++; if (int_out !== 1'b0) $display("FAIL nest_still_low got %b want 0", int_out); else n_pass++;
        do_eoi_ns();
        n_checks++; if (isr_out !== 8'h00) $display("FAIL nest_eoi2 got %h want 00", isr_out); else n_pass++;
        tick();
        n_checks++; if (int_out !== 1'b1) $display("FAIL nest_int5 got %b want 1", int_out); else n_pass++;
    endtask

    task automatic test_rotation();
        do_reset();
        rotate_en = 1'b1; aeoi = 1'b1;
        irq_in = 8'h05;
        tick(); tick();
        n_checks++; if (int_out !== 1'b1) $display("FAIL rot_int got %b want 1", int_out); else n_pass++;
        do_ack();
        n_checks++; if (vec_id !== 3'd0) $display("FAIL rot_vid0 got %0d want 0", vec_id); else n_pass++;
        n_checks++; if (isr_out !== 8'h00) $display("FAIL rot_aeoi got %h want 00", isr_out); else n_pass++;
        do_ack();
        n_checks++; if (vec_id !== 3'd2) $display("FAIL rot_vid2 got %0d want 2", vec_id); else n_pass++;
        irq_in = 8'h00; tick();
        irq_in = 8'h0a; tick();
        do_ack();
        n_checks++; if (vec_id !== 3'd3) $display("FAIL rot_vid3 got %0d want 3", vec_id); else n_pass++;
        irq_in = 8'h00; tick();
        irq_in = 8'h01; tick();
        do_ack();
        n_checks++; if (vec_id !== 3'd0) $display("FAIL rot_vid0b got %0d want 0", vec_id); else n_pass++;
        do_ack();
        n_checks++; if (vec_id !== 3'd1) $display("FAIL rot_vid1 got %0d want 1", vec_id); else n_pass++;
        n_checks++; if (irr_out !== 8'h00) $display("FAIL rot_irr got %h want 00", irr_out); else n_pass++;
        rotate_en = 1'b0; aeoi = 1'b0;
    endtask

    task automatic test_spurious_mask();
        do_reset();
        irq_in = 8'h40;
        tick(); tick();
        n_checks++; if (int_out !== 1'b1) $display("FAIL spur_int got %b want 1", int_out); else n_pass++;
        mask = 8'h40;
        tick();
        n_checks++; if (int_out !== 1'b0) $display("FAIL spur_masked_int got %b want 0", int_out); else n_pass++;
        do_ack();
        n_checks++; if (vec_id !== 3'd7) $display("FAIL spur_vid got %0d want 7", vec_id); else n_pass++;
        n_checks++; if (vec_spurious !== 1'b1) $display("FAIL spur_flag got %b want 1", vec_spurious); else n_pass++;
        n_checks++; if (isr_out !== 8'h00) $display("FAIL spur_isr got %h want 00", isr_out); else n_pass++;
        n_checks++; if (irr_out !== 8'h40) $display("FAIL spur_irr got %h want 40", irr_out); else n_pass++;
        mask = 8'h00;
    endtask

    task automatic test_level();
        do_reset();
        level_mode = 1'b1;
        irq_in = 8'h10;
        tick();
        irq_in = 8'h00;
        n_checks++; if (irr_out !== 8'h10) $display("FAIL lvl_irr_set got %h want 10", irr_out); else n_pass++;
        tick();
        n_checks++; if (irr_out !== 8'h00) $display("FAIL lvl_irr_follow got %h want 00", irr_out); else n_pass++;
        tick();
        n_checks++; if (int_out !== 1'b0) $display("FAIL lvl_int_drop got %b want 0", int_out); else n_pass++;
        do_ack();
        n_checks++; if (vec_spurious !== 1'b1) $display("FAIL lvl_spur got %b want 1", vec_spurious); else n_pass++;
        irq_in = 8'h10;
        tick(); tick(); tick();
        n_checks++; if (int_out !== 1'b1) $display("FAIL lvl_int_hold got %b want 1", int_out); else n_pass++;
        do_ack();
        n_checks++; if (vec_id !== 3'd4) $display("FAIL lvl_vid got %0d want 4", vec_id); else n_pass++;
        n_checks++; if (irr_out !== 8'h10) $display("FAIL lvl_irr_kept got %h want 10", irr_out); else n_pass++;
        level_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        irq_in = 8'h08;
        tick(); tick();
        inta = 1'b1; tick(); inta = 1'b0;
        n_checks++; if (isr_out !== 8'h08) $display("FAIL rmid_isr got %h want 08", isr_out); else n_pass++;
        reset = 1'b1; tick(); reset = 1'b0;
        n_checks++; if ({int_out, vec_valid, vec_spurious} !== 3'b000) $display("FAIL rmid_flags got %b want 000", {int_out, vec_valid, vec_spurious}); else n_pass++;
        n_checks++; if ({irr_out, isr_out} !== 16'h0000) $display("FAIL rmid_regs got %h want 0000", {irr_out, isr_out}); else n_pass++;
        inta = 1'b1;
        tick();
        n_checks++; if (vec_valid !== 1'b0) $display("FAIL rmid_first got %b want 0", vec_valid); else n_pass++;
        tick();
        inta = 1'b0;
        n_checks++; if (vec_valid !== 1'b1) $display("FAIL rmid_second got %b want 1", vec_valid); else n_pass++;
        n_checks++; if ({vec_spurious, vec_id} !== 4'b1111) $display("FAIL rmid_vec got %b want 1111", {vec_spurious, vec_id}); else n_pass++;
        n_checks++; if (irr_out !== 8'h08) $display("FAIL rmid_irr got %h want 08", irr_out); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
            if ($urandom_range(0, 31) == 0)  mask = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 199) == 0) level_mode = ~level_mode;
            if ($urandom_range(0, 63) == 0)  rotate_en = ~rotate_en;
            if ($urandom_range(0, 63) == 0)  aeoi = ~aeoi;
            inta         = ($urandom_range(0, 3) == 0);
            eoi_valid    = ($urandom_range(0, 5) == 0);
            eoi_specific = 1'($urandom);
            eoi_id       = 3'($urandom_range(0, 7));
            reset        = ($urandom_range(0, 299) == 0);
            tick();
            n_checks++; if (irr_out !== m_irr) $display("FAIL rnd_irr cyc %0d got %h want %h", cyc, irr_out, m_irr); else n_pass++;
            n_checks++; if (isr_out !== m_isr) $display("FAIL rnd_isr cyc %0d got %h want %h", cyc, isr_out, m_isr); else n_pass++;
            n_checks++; if (int_out !== m_int) $display("FAIL rnd_int cyc %0d got %b want %b", cyc, int_out, m_int); else n_pass++;
            n_checks++; if (vec_valid !== m_vv) $display("FAIL rnd_vv cyc %0d got %b want %b", cyc, vec_valid, m_vv); else n_pass++;
            if (m_vv) begin
                n_checks++; if (int'(vec_id) != m_vid || vec_spurious !== m_vsp) $display("FAIL rnd_vec cyc %0d got %0d/%b want %0d/%b", cyc, vec_id, vec_spurious, m_vid, m_vsp); else n_pass++;
            end
        end
        reset = 1'b0; inta = 1'b0; eoi_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; mask = '0; level_mode = 1'b0; rotate_en = 1'b0;
        aeoi = 1'b0; inta = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_id = '0;
        test_reset();
        test_basic_ack();
        test_nesting();
        test_rotation();
        test_spurious_mask();
        test_level();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
